sdram_cmd_queue: RTL

Request buffer sitting directly upstream of `sdram_controller`. Accepts read/write commands from a host over a valid/ready handshake and stores them in a FIFO. Replays them into the controller's `rd_req`/`wr_req` level-and-grant handshake and returns read data to the host. Decouples host bursts from controller stalls during init, refresh and row activation.

---
 rtl/sdram_pkg.sv | 41 ++++
 rtl/sdram_cmd_queue_if.sv | 25 ++
 rtl/sdram_cmd_fifo.sv | 55 +++++
 rtl/sdram_cmd_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types for the SDRAM command queue.
// Holds the queue FSM state enum, the command-type constants and the
// FIFO entry layout {we, bank, addr, wdata}.
package sdram_pkg;

  localparam int CMDQ_ADDR_W = 24;
  localparam int CMDQ_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } cmdq_state_e;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_type_e;

  typedef struct packed {
    cmd_type_e                we;
    logic [1:0]               bank;
    logic [CMDQ_ADDR_W-1:0]   addr;
    logic [CMDQ_DATA_W-1:0]   wdata;
  } cmd_entry_t;

  localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

  function automatic cmd_entry_t pack_cmd(input logic                   we,
                                          input logic [1:0]             bank,
                                          input logic [CMDQ_ADDR_W-1:0] addr,
                                          input logic [CMDQ_DATA_W-1:0] wdata);
    cmd_entry_t e;
    e.we    = we ? CMD_WR : CMD_RD;
    e.bank  = bank;
    e.addr  = addr;
    e.wdata = wdata;
    return e;
  endfunction

endpackage

// File: rtl/sdram_cmd_queue_if.sv
// sdram_cmd_queue_if: host-side command/response bus of the SDRAM command
// queue. master = host, slave = queue.
interface sdram_cmd_queue_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_bank;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_bank, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_bank, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sdram_cmd_fifo.sv
// sdram_cmd_fifo: synchronous FIFO, DEPTH entries (power of two) of WIDTH
// bits. Push when full and pop when empty are ignored. Head is visible
// combinationally on rdata; there is no push-to-pop bypass.
module sdram_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_cmd_queue.sv
// sdram_cmd_queue: command buffer in front of sdram_controller. Host
// commands are queued and replayed one at a time into the controller's
// rd_req/wr_req level-and-grant handshake; read data returns as a one-cycle
// rsp_valid pulse. Optional feature macro: SDRAM_CMDQ_STATS_EN adds 16-bit
// wrapping granted-write/granted-read counters (stat_wr_cnt, stat_rd_cnt).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no request out; loads FIFO head into outputs if non-empty
// ST_ISSUE   | rd_req or wr_req high, fields held until matching grant
// ST_WAIT_RD | read granted, waiting for rd_data_valid from controller
//
// ADDR_W/DATA_W must match the widths of sdram_pkg::cmd_entry_t.
module sdram_cmd_queue
  import sdram_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = CMDQ_ADDR_W,
  parameter int DATA_W = CMDQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  sdram_cmd_queue_if.slave  host,
  output logic              rd_req,
  output logic              wr_req,
  output logic [ADDR_W-1:0] in_addr,
  output logic [1:0]        bank_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rd_gnt,
  input  logic              wr_gnt,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic              busy
`ifdef SDRAM_CMDQ_STATS_EN
  ,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_rd_cnt
`endif
);
  localparam int CNT_W = $clog2(DEPTH+1);

  cmdq_state_e             state, state_d;
  cmd_entry_t              push_entry;
  cmd_entry_t              head_entry;
  logic [CMD_ENTRY_W-1:0]  head_bits;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    push;
  logic                    pop;
  logic                    load;
  logic                    wr_grant;
  logic                    rd_grant;
  logic                    rsp_fire;
  logic                    rsp_valid_q;
  logic [DATA_W-1:0]       rsp_data_q;

  assign host.cmd_ready = !fifo_full;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign push           = host.cmd_valid && !fifo_full;
  assign head_entry     = cmd_entry_t'(head_bits);
  assign busy           = (fifo_count != '0) || (state != ST_IDLE);

  // Pack the host command into a FIFO entry.
  always_comb begin
    push_entry = pack_cmd(host.cmd_we, host.cmd_bank, host.cmd_addr, host.cmd_wdata);
  end

  sdram_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next state and strobes; a grant of the wrong type matches neither arm.
  always_comb begin
    state_d  = state;
    load     = 1'b0;
    pop      = 1'b0;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    rsp_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wr_req && wr_gnt) begin
          wr_grant = 1'b1;
          pop      = 1'b1;
          state_d  = ST_IDLE;
        end else if (rd_req && rd_gnt) begin
          rd_grant = 1'b1;
          pop      = 1'b1;
          state_d  = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (rd_data_valid) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller-side request/field registers and host response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_req      <= 1'b0;
      wr_req      <= 1'b0;
      in_addr     <= '0;
      bank_addr   <= '0;
      wr_data     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) rsp_data_q <= rd_data;
      if (load) begin
        in_addr   <= head_entry.addr;
        bank_addr <= head_entry.bank;
        wr_data   <= head_entry.wdata;
        wr_req    <= (head_entry.we == CMD_WR);
        rd_req    <= (head_entry.we == CMD_RD);
      end else if (wr_grant || rd_grant) begin
        wr_req <= 1'b0;
        rd_req <= 1'b0;
      end
    end
  end

`ifdef SDRAM_CMDQ_STATS_EN
  // Granted-command counters, free-running and wrapping at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      if (wr_grant) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (rd_grant) stat_rd_cnt <= stat_rd_cnt + 16'd1;
    end
  end
`endif

endmodule
